// File: rtl/project1_pkg.sv
// Shared encodings for the Project 1 operand entry front end.
package project1_pkg;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'b00,
    ST_ENTER_B = 2'b01,
    ST_SHOW    = 2'b10
  } entry_state_t;

  localparam int BTN_ACCEPT = 0;
  localparam int BTN_CLEAR  = 1;

  localparam int DATA_W = 8;
  localparam int MODE_W = 2;
  localparam int SW_W   = DATA_W + MODE_W;

endpackage

// File: rtl/operand_entry_if.sv
// Board-side inputs and ALU-side operand outputs of the entry front end.
interface operand_entry_if;
  import project1_pkg::*;

  logic [1:0]        buttons;
  logic [SW_W-1:0]   switches;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic [MODE_W-1:0] mode;
  logic              result_valid;
  logic [1:0]        entry_state;
  logic [DATA_W-1:0] display_value;

  modport master (
    output buttons, switches,
    input  operand_a, operand_b, mode, result_valid, entry_state, display_value
  );

  modport slave (
    input  buttons, switches,
    output operand_a, operand_b, mode, result_valid, entry_state, display_value
  );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus counting debouncer for one active-low push-button.
// press pulses for one cycle when the debounced level falls (button pressed).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic resetn,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_p0;
  logic             sync_p1;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
      stable  <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Any cycle matching the accepted level restarts the count, so bounces never accumulate
      if (sync_p1 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= sync_p1;
        cnt    <= '0;
        press  <= stable;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/operand_entry.sv
// Debounced button entry FSM that latches two operands and a mode from the switches
// and presents them, registered, to the ALU datapath.
module operand_entry
  import project1_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clock,
  input  logic             resetn,
  operand_entry_if.slave   bus
);

  logic press_acc;
  logic press_clr;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_accept (
    .clock  (clock),
    .resetn (resetn),
    .btn    (bus.buttons[BTN_ACCEPT]),
    .press  (press_acc)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
    .clock  (clock),
    .resetn (resetn),
    .btn    (bus.buttons[BTN_CLEAR]),
    .press  (press_clr)
  );

  logic [SW_W-1:0] sw_p0;
  logic [SW_W-1:0] sw_p1;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sw_p0 <= '0;
      sw_p1 <= '0;
    end else begin
      sw_p0 <= bus.switches;
      sw_p1 <= sw_p0;
    end
  end

  entry_state_t      state, state_nxt;
  logic [DATA_W-1:0] opa, opa_nxt;
  logic [DATA_W-1:0] opb, opb_nxt;
  logic [MODE_W-1:0] md, md_nxt;
  logic              vld, vld_nxt;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= ST_ENTER_A;
      opa   <= '0;
      opb   <= '0;
      md    <= '0;
      vld   <= 1'b0;
    end else begin
      state <= state_nxt;
      opa   <= opa_nxt;
      opb   <= opb_nxt;
      md    <= md_nxt;
      vld   <= vld_nxt;
    end
  end

  // CLEAR takes priority; a coincident ACCEPT pulse is simply dropped
  always_comb begin
    state_nxt = state;
    opa_nxt   = opa;
    opb_nxt   = opb;
    md_nxt    = md;
    vld_nxt   = vld;
    if (press_clr) begin
      state_nxt = ST_ENTER_A;
      opa_nxt   = '0;
      opb_nxt   = '0;
      md_nxt    = '0;
      vld_nxt   = 1'b0;
    end else if (press_acc) begin
      case (state)
        ST_ENTER_A: begin
          opa_nxt   = sw_p1[DATA_W-1:0];
          state_nxt = ST_ENTER_B;
        end
        ST_ENTER_B: begin
          opb_nxt   = sw_p1[DATA_W-1:0];
          md_nxt    = sw_p1[SW_W-1:DATA_W];
          vld_nxt   = 1'b1;
          state_nxt = ST_SHOW;
        end
        ST_SHOW: begin
          vld_nxt   = 1'b0;
          state_nxt = ST_ENTER_A;
        end
        default: begin
          state_nxt = ST_ENTER_A;
        end
      endcase
    end
  end

  assign bus.operand_a     = opa;
  assign bus.operand_b     = opb;
  assign bus.mode          = md;
  assign bus.result_valid  = vld;
  assign bus.entry_state   = state;
  assign bus.display_value = (state == ST_SHOW) ? opa : sw_p1[DATA_W-1:0];

endmodule
